// File: rtl/dt_param_engine.sv
// dt_param_engine: two-pass distance transform over a packed binary image.
// LOAD unpacks ROM words into the result RAM as 0/1 pixels. FWD then walks
// the image in raster order using the causal neighbours. BWD walks it in
// reverse order using the anti-causal neighbours. Every cycle performs at
// most one memory operation. Read data is consumed combinationally in the
// cycle it arrives, so there are no bubbles between accesses.
module dt_param_engine #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int STI_W = 16,
  parameter int PIX_W = 8,
  parameter int MODE  = 0,
  localparam int N_PIX = IMG_W * IMG_H,
  localparam int SA_W  = $clog2(N_PIX / STI_W),
  localparam int RA_W  = $clog2(N_PIX)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             fwpass_finish,
  output logic             done,
  output logic             sti_rd,
  output logic [SA_W-1:0]  sti_addr,
  input  logic [STI_W-1:0] sti_di,
  output logic             res_rd,
  output logic             res_wr,
  output logic [RA_W-1:0]  res_addr,
  output logic [PIX_W-1:0] res_do,
  input  logic [PIX_W-1:0] res_di
);

  localparam int CW      = $clog2(IMG_W);
  localparam int N_WORDS = N_PIX / STI_W;
  localparam int BW      = (STI_W > 1) ? $clog2(STI_W) : 1;
  localparam int NBRS    = (MODE == 0) ? 4 : 2;
  localparam logic [PIX_W-1:0] PIX_MAX = {PIX_W{1'b1}};

  // Each state names the memory operation being driven in the current cycle.
  typedef enum logic [3:0] {
    S_IDLE, S_LOAD_RD, S_LOAD_WR,
    S_FWD_SELF, S_FWD_NBR, S_FWD_WR,
    S_BWD_SELF, S_BWD_NBR, S_BWD_WR
  } state_t;

  state_t             state_q, state_d;
  logic [RA_W-1:0]    pix_q, pix_d;
  logic [SA_W-1:0]    word_q, word_d;
  logic [BW-1:0]      bit_q, bit_d;
  logic [STI_W-1:0]   shift_q, shift_d;
  logic [2:0]         nbr_q, nbr_d;
  logic [PIX_W-1:0]   min_q, min_d;
  logic [PIX_W-1:0]   self_q, self_d;
  logic               busy_q, busy_d;
  logic               fwfin_q, fwfin_d;
  logic               done_q, done_d;
  logic               sti_rd_q, sti_rd_d;
  logic [SA_W-1:0]    sti_addr_q, sti_addr_d;
  logic               res_rd_q, res_rd_d;
  logic               res_wr_q, res_wr_d;
  logic [RA_W-1:0]    res_addr_q, res_addr_d;
  logic [PIX_W-1:0]   res_do_q, res_do_d;

  logic               bwd_s, scan_s, adv_s;
  logic [2:0]         k_s;
  logic [PIX_W-1:0]   m_s, self_s, val_s;

  // Neighbour offset {dr, dc}, each a 2-bit signed value in -1..+1.
  function automatic logic [3:0] nbr_off(input logic bwd, input logic [1:0] idx);
    logic [3:0] off;
    off = 4'b0000;
    if (MODE == 0) begin
      case ({bwd, idx})
        3'b000:  off = 4'b1111;  // NW
        3'b001:  off = 4'b1100;  // N
        3'b010:  off = 4'b1101;  // NE
        3'b011:  off = 4'b0011;  // W
        3'b100:  off = 4'b0001;  // E
        3'b101:  off = 4'b0111;  // SW
        3'b110:  off = 4'b0100;  // S
        3'b111:  off = 4'b0101;  // SE
        default: off = 4'b0000;
      endcase
    end else begin
      case ({bwd, idx})
        3'b000:  off = 4'b1100;  // N
        3'b001:  off = 4'b0011;  // W
        3'b100:  off = 4'b0001;  // E
        3'b101:  off = 4'b0100;  // S
        default: off = 4'b0000;
      endcase
    end
    return off;
  endfunction

  // Row and column are checked separately so that a column step off the
  // edge is rejected instead of wrapping into the adjacent row.
  function automatic logic nbr_valid(input logic bwd, input logic [1:0] idx,
                                     input logic [RA_W-1:0] pix);
    logic [3:0] off;
    int r;
    int c;
    off = nbr_off(bwd, idx);
    r = int'(pix >> CW) + int'($signed(off[3:2]));
    c = int'(pix[CW-1:0]) + int'($signed(off[1:0]));
    return (int'(idx) < NBRS) && (r >= 0) && (r < IMG_H) && (c >= 0) && (c < IMG_W);
  endfunction

  function automatic logic [RA_W-1:0] nbr_addr(input logic bwd, input logic [1:0] idx,
                                               input logic [RA_W-1:0] pix);
    logic [3:0] off;
    int delta;
    off = nbr_off(bwd, idx);
    delta = int'($signed(off[3:2])) * IMG_W + int'($signed(off[1:0]));
    return pix + RA_W'(delta);
  endfunction

  // Lowest in-image neighbour index >= start_idx. Returns NBRS when none is left.
  function automatic logic [2:0] first_valid(input logic bwd, input logic [2:0] start_idx,
                                             input logic [RA_W-1:0] pix);
    logic [2:0] k;
    k = 3'(NBRS);
    for (int i = 3; i >= 0; i--) begin
      if ((i >= int'(start_idx)) && nbr_valid(bwd, 2'(i), pix)) k = 3'(i);
    end
    return k;
  endfunction

  // Any out-of-image neighbour contributes a 0 to the minimum.
  function automatic logic any_oob(input logic bwd, input logic [RA_W-1:0] pix);
    logic oob;
    oob = 1'b0;
    for (int i = 0; i < NBRS; i++) begin
      if (!nbr_valid(bwd, 2'(i), pix)) oob = 1'b1;
    end
    return oob;
  endfunction

  function automatic logic [PIX_W-1:0] sat_inc(input logic [PIX_W-1:0] x);
    return (x == PIX_MAX) ? x : x + PIX_W'(1);
  endfunction

  function automatic logic [PIX_W-1:0] pmin(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  // Next-state and next-output logic for the single-operation-per-cycle sequencer.
  always_comb begin
    state_d    = state_q;
    pix_d      = pix_q;
    word_d     = word_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    nbr_d      = nbr_q;
    min_d      = min_q;
    self_d     = self_q;
    busy_d     = busy_q;
    fwfin_d    = 1'b0;
    done_d     = 1'b0;
    sti_rd_d   = 1'b0;
    sti_addr_d = '0;
    res_rd_d   = 1'b0;
    res_wr_d   = 1'b0;
    res_addr_d = '0;
    res_do_d   = '0;
    bwd_s      = (state_q == S_BWD_SELF) || (state_q == S_BWD_NBR) || (state_q == S_BWD_WR);
    scan_s     = 1'b0;
    adv_s      = 1'b0;
    k_s        = 3'd0;
    m_s        = '0;
    self_s     = self_q;
    val_s      = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_LOAD_RD;
          busy_d     = 1'b1;
          word_d     = '0;
          pix_d      = '0;
          sti_rd_d   = 1'b1;
          sti_addr_d = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD_RD: begin
        state_d    = S_LOAD_WR;
        bit_d      = '0;
        shift_d    = {sti_di[STI_W-2:0], 1'b0};
        res_wr_d   = 1'b1;
        res_addr_d = pix_q;
        res_do_d   = PIX_W'(sti_di[STI_W-1]);
        pix_d      = pix_q + RA_W'(1);
      end
      S_LOAD_WR: begin
        if (bit_q != BW'(STI_W - 1)) begin
          bit_d      = bit_q + BW'(1);
          shift_d    = {shift_q[STI_W-2:0], 1'b0};
          res_wr_d   = 1'b1;
          res_addr_d = pix_q;
          res_do_d   = PIX_W'(shift_q[STI_W-1]);
          pix_d      = pix_q + RA_W'(1);
        end else if (word_q != SA_W'(N_WORDS - 1)) begin
          state_d    = S_LOAD_RD;
          word_d     = word_q + SA_W'(1);
          sti_rd_d   = 1'b1;
          sti_addr_d = word_q + SA_W'(1);
        end else begin
          state_d    = S_FWD_SELF;
          pix_d      = '0;
          res_rd_d   = 1'b1;
          res_addr_d = '0;
        end
      end
      S_FWD_SELF, S_BWD_SELF: begin
        if (res_di == '0) begin
          adv_s = 1'b1;
        end else begin
          self_d = res_di;
          self_s = res_di;
          m_s    = any_oob(bwd_s, pix_q) ? '0 : PIX_MAX;
          min_d  = m_s;
          k_s    = first_valid(bwd_s, 3'd0, pix_q);
          scan_s = 1'b1;
        end
      end
      S_FWD_NBR, S_BWD_NBR: begin
        m_s    = pmin(min_q, res_di);
        min_d  = m_s;
        k_s    = first_valid(bwd_s, nbr_q + 3'd1, pix_q);
        scan_s = 1'b1;
      end
      S_FWD_WR, S_BWD_WR: begin
        adv_s = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Either fetch the next in-image neighbour or resolve this pixel.
    if (scan_s) begin
      if (k_s < 3'(NBRS)) begin
        state_d    = bwd_s ? S_BWD_NBR : S_FWD_NBR;
        nbr_d      = k_s;
        res_rd_d   = 1'b1;
        res_addr_d = nbr_addr(bwd_s, k_s[1:0], pix_q);
      end else if (!bwd_s) begin
        state_d    = S_FWD_WR;
        res_wr_d   = 1'b1;
        res_addr_d = pix_q;
        res_do_d   = sat_inc(m_s);
      end else begin
        val_s = pmin(self_s, sat_inc(m_s));
        if (val_s != self_s) begin
          state_d    = S_BWD_WR;
          res_wr_d   = 1'b1;
          res_addr_d = pix_q;
          res_do_d   = val_s;
        end else begin
          adv_s = 1'b1;
        end
      end
    end else begin
      scan_s = 1'b0;
    end

    // Move to the next pixel, issuing its self read in the same cycle.
    if (adv_s) begin
      if (!bwd_s) begin
        if (pix_q == RA_W'(N_PIX - 1)) begin
          fwfin_d    = 1'b1;
          state_d    = S_BWD_SELF;
          pix_d      = RA_W'(N_PIX - 1);
          res_rd_d   = 1'b1;
          res_addr_d = RA_W'(N_PIX - 1);
        end else begin
          state_d    = S_FWD_SELF;
          pix_d      = pix_q + RA_W'(1);
          res_rd_d   = 1'b1;
          res_addr_d = pix_q + RA_W'(1);
        end
      end else if (pix_q == '0) begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end else begin
        state_d    = S_BWD_SELF;
        pix_d      = pix_q - RA_W'(1);
        res_rd_d   = 1'b1;
        res_addr_d = pix_q - RA_W'(1);
      end
    end else begin
      adv_s = 1'b0;
    end
  end

  // State and registered-output update; reset aborts any pass immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pix_q      <= '0;
      word_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      nbr_q      <= 3'd0;
      min_q      <= '0;
      self_q     <= '0;
      busy_q     <= 1'b0;
      fwfin_q    <= 1'b0;
      done_q     <= 1'b0;
      sti_rd_q   <= 1'b0;
      sti_addr_q <= '0;
      res_rd_q   <= 1'b0;
      res_wr_q   <= 1'b0;
      res_addr_q <= '0;
      res_do_q   <= '0;
    end else begin
      state_q    <= state_d;
      pix_q      <= pix_d;
      word_q     <= word_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      nbr_q      <= nbr_d;
      min_q      <= min_d;
      self_q     <= self_d;
      busy_q     <= busy_d;
      fwfin_q    <= fwfin_d;
      done_q     <= done_d;
      sti_rd_q   <= sti_rd_d;
      sti_addr_q <= sti_addr_d;
      res_rd_q   <= res_rd_d;
      res_wr_q   <= res_wr_d;
      res_addr_q <= res_addr_d;
      res_do_q   <= res_do_d;
    end
  end

  assign busy          = busy_q;
  assign fwpass_finish = fwfin_q;
  assign done          = done_q;
  assign sti_rd        = sti_rd_q;
  assign sti_addr      = sti_addr_q;
  assign res_rd        = res_rd_q;
  assign res_wr        = res_wr_q;
  assign res_addr      = res_addr_q;
  assign res_do        = res_do_q;

endmodule

// File: tb/tb_dt_param_engine.sv
// Directed bench for dt_param_engine on 8x8 images: three instances cover
// MODE 0 (8-bit), MODE 1 (8-bit) and MODE 0 with 2-bit saturating results.
module tb_dt_param_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] start_v;
  logic       clr_mem;
  int         n_chk = 0;
  int         n_fail = 0;
  int         rdwr_viol = 0;

  logic [7:0] rom [8];
  logic [7:0] ram0 [64];
  logic [7:0] ram1 [64];
  logic [1:0] ram2 [64];

  logic       busy0, busy1, busy2, fw0, fw1, fw2, done0, done1, done2;
  logic       sti_rd0, sti_rd1, sti_rd2, res_rd0, res_rd1, res_rd2, res_wr0, res_wr1, res_wr2;
  logic [2:0] sti_addr0, sti_addr1, sti_addr2;
  logic [7:0] sti_di0 = 8'h00, sti_di1 = 8'h00, sti_di2 = 8'h00;
  logic [5:0] res_addr0, res_addr1, res_addr2;
  logic [7:0] res_do0, res_do1, res_di0 = 8'h00, res_di1 = 8'h00;
  logic [1:0] res_do2, res_di2 = 2'b00;
  logic [2:0] busy_v, fw_v, done_v;

  assign busy_v = {busy2, busy1, busy0};
  assign fw_v   = {fw2, fw1, fw0};
  assign done_v = {done2, done1, done0};

  always #5 clk = ~clk;

  dt_param_engine #(.IMG_W(8), .IMG_H(8), .STI_W(8), .PIX_W(8), .MODE(0)) dut0 (
    .clk(clk), .reset(reset), .start(start_v[0]), .busy(busy0), .fwpass_finish(fw0),
    .done(done0), .sti_rd(sti_rd0), .sti_addr(sti_addr0), .sti_di(sti_di0),
    .res_rd(res_rd0), .res_wr(res_wr0), .res_addr(res_addr0), .res_do(res_do0), .res_di(res_di0));

  dt_param_engine #(.IMG_W(8), .IMG_H(8), .STI_W(8), .PIX_W(8), .MODE(1)) dut1 (
    .clk(clk), .reset(reset), .start(start_v[1]), .busy(busy1), .fwpass_finish(fw1),
    .done(done1), .sti_rd(sti_rd1), .sti_addr(sti_addr1), .sti_di(sti_di1),
    .res_rd(res_rd1), .res_wr(res_wr1), .res_addr(res_addr1), .res_do(res_do1), .res_di(res_di1));

  dt_param_engine #(.IMG_W(8), .IMG_H(8), .STI_W(8), .PIX_W(2), .MODE(0)) dut2 (
    .clk(clk), .reset(reset), .start(start_v[2]), .busy(busy2), .fwpass_finish(fw2),
    .done(done2), .sti_rd(sti_rd2), .sti_addr(sti_addr2), .sti_di(sti_di2),
    .res_rd(res_rd2), .res_wr(res_wr2), .res_addr(res_addr2), .res_do(res_do2), .res_di(res_di2));

  // ROM and RAM read ports: capture on the falling edge of the request cycle.
  always @(negedge clk) begin
    if (sti_rd0) sti_di0 <= rom[sti_addr0];
    if (sti_rd1) sti_di1 <= rom[sti_addr1];
    if (sti_rd2) sti_di2 <= rom[sti_addr2];
    if (res_rd0) res_di0 <= ram0[res_addr0];
    if (res_rd1) res_di1 <= ram1[res_addr1];
    if (res_rd2) res_di2 <= ram2[res_addr2];
  end

  // RAM write ports, plus a bulk fill with junk so LOAD has to overwrite it.
  always @(posedge clk) begin
    if (clr_mem) begin
      for (int i = 0; i < 64; i++) begin
        ram0[i] <= 8'hAA;
        ram1[i] <= 8'hAA;
        ram2[i] <= 2'b10;
      end
    end else begin
      if (res_wr0) ram0[res_addr0] <= res_do0;
      if (res_wr1) ram1[res_addr1] <= res_do1;
      if (res_wr2) ram2[res_addr2] <= res_do2;
    end
  end

  // Read and write must never share a cycle on any instance.
  always @(negedge clk) begin
    if ((res_rd0 && res_wr0) || (res_rd1 && res_wr1) || (res_rd2 && res_wr2)) rdwr_viol++;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int get_ram(input int d, input int a);
    case (d)
      0:       return int'(ram0[a]);
      1:       return int'(ram1[a]);
      default: return int'(ram2[a]);
    endcase
  endfunction

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Hand-derived final distance maps: 0 = single pixel, 1 = 5x5 block, 2 = all ones capped at 3.
  function automatic int exp_px(input int kind, input int r, input int c);
    case (kind)
      0:       return (r == 4 && c == 4) ? 1 : 0;
      1:       return (r >= 1 && r <= 5 && c >= 1 && c <= 5) ?
                      min2(min2(r, c), min2(6 - r, 6 - c)) : 0;
      default: return min2(3, min2(min2(r + 1, c + 1), min2(8 - r, 8 - c)));
    endcase
  endfunction

  task automatic set_rom(input int kind);
    for (int r = 0; r < 8; r++) begin
      case (kind)
        0:       rom[r] = (r == 4) ? 8'h08 : 8'h00;
        1:       rom[r] = (r >= 1 && r <= 5) ? 8'h7C : 8'h00;
        default: rom[r] = 8'hFF;
      endcase
    end
  endtask

  task automatic clear_mem();
    @(negedge clk) clr_mem = 1'b1;
    @(negedge clk) clr_mem = 1'b0;
  endtask

  task automatic cmp_img(input string tag, input int d, input int kind);
    int nbad;
    nbad = 0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        if (get_ram(d, r * 8 + c) != exp_px(kind, r, c)) nbad++;
    check(tag, nbad, 0);
  endtask

  // Start one instance, optionally poke start while busy, snapshot two
  // pixels at the forward-pass pulse and check the handshake shape.
  task automatic run_dut(input int d, input bit poke, input int a0, input int a1,
                         output int snap0, output int snap1, output int done_cyc);
    int fw_cyc;
    int ndone;
    int busy_at_done;
    int busy_first;
    fw_cyc = -1; done_cyc = -1; ndone = 0; busy_at_done = -1; busy_first = -1;
    snap0 = -1; snap1 = -1;
    @(posedge clk); #1 start_v[d] = 1'b1;
    @(posedge clk); #1 start_v[d] = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      start_v[d] = poke && (cyc == 20 || cyc == 150);
      if (cyc == 0) busy_first = int'(busy_v[d]);
      if (fw_v[d] && fw_cyc < 0) begin
        fw_cyc = cyc;
        snap0  = get_ram(d, a0);
        snap1  = get_ram(d, a1);
      end
      if (done_v[d]) begin
        ndone++;
        if (done_cyc < 0) begin
          done_cyc     = cyc;
          busy_at_done = int'(busy_v[d]);
        end
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 30) break;
    end
    start_v[d] = 1'b0;
    check("busy_after_start", busy_first, 1);
    check("done_pulse_count", ndone, 1);
    check("fwfin_before_done", int'(fw_cyc >= 0 && fw_cyc < done_cyc), 1);
    check("busy_at_done", busy_at_done, 0);
    check("busy_after_done", int'(busy_v[d]), 0);
  endtask

  initial begin
    int s0, s1, done_b, done_e;
    reset = 1'b1; start_v = 3'b000; clr_mem = 1'b0;
    set_rom(0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl0", int'({busy0, fw0, done0, sti_rd0, res_rd0, res_wr0}), 0);
    check("reset_addr0", int'({sti_addr0, res_addr0, res_do0}), 0);
    check("reset_busy_all", int'(busy_v | done_v | fw_v), 0);
    @(negedge clk) reset = 1'b0;

    // Single object pixel, 8-neighbour.
    set_rom(0); clear_mem();
    run_dut(0, 1'b0, 36, 0, s0, s1, done_e);
    check("A_fw_p36", s0, 1);
    check("A_p36", get_ram(0, 36), 1);
    cmp_img("A_image", 0, 0);

    // 5x5 block, 8-neighbour, with stray start pulses while busy.
    set_rom(1); clear_mem();
    run_dut(0, 1'b1, 27, 45, s0, s1, done_b);
    check("B_fw_3_3", s0, 3);
    check("B_fw_5_5", s1, 1);
    check("B_3_3", get_ram(0, 27), 3);
    check("B_2_2", get_ram(0, 18), 2);
    check("B_1_1", get_ram(0, 9), 1);
    check("B_5_5", get_ram(0, 45), 1);
    cmp_img("B_image", 0, 1);

    // Same block, 4-neighbour.
    clear_mem();
    run_dut(1, 1'b0, 27, 45, s0, s1, done_e);
    check("C_fw_3_3", s0, 3);
    check("C_fw_5_5", s1, 5);
    check("C_3_3", get_ram(1, 27), 3);
    check("C_1_3", get_ram(1, 11), 1);
    check("C_2_3", get_ram(1, 19), 2);
    cmp_img("C_image", 1, 1);

    // All ones with 2-bit results: image edges are background, values saturate.
    set_rom(2); clear_mem();
    run_dut(2, 1'b0, 0, 27, s0, s1, done_e);
    check("D_0_0", get_ram(2, 0), 1);
    check("D_1_1", get_ram(2, 9), 2);
    check("D_3_3_sat", get_ram(2, 27), 3);
    begin
      int nz;
      nz = 0;
      for (int i = 0; i < 64; i++) if (get_ram(2, i) == 0) nz++;
      check("D_no_zero", nz, 0);
    end
    cmp_img("D_image", 2, 2);

    // Reset in the middle of the forward pass, then a clean rerun.
    set_rom(1); clear_mem();
    @(posedge clk); #1 start_v[0] = 1'b1;
    @(posedge clk); #1 start_v[0] = 1'b0;
    repeat (110) @(negedge clk);
    check("E_busy_before_reset", int'(busy0), 1);
    @(posedge clk); #2 reset = 1'b1;
    #1;
    check("E_ctrl_in_reset", int'({busy0, fw0, done0, sti_rd0, res_rd0, res_wr0}), 0);
    check("E_addr_in_reset", int'({sti_addr0, res_addr0, res_do0}), 0);
    @(negedge clk) reset = 1'b0;
    run_dut(0, 1'b0, 27, 45, s0, s1, done_e);
    check("E_fw_3_3", s0, 3);
    cmp_img("E_image", 0, 1);
    check("E_same_latency", done_e, done_b);

    check("rd_wr_exclusive", rdwr_viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
